// File: rtl/dmem_pkg.sv
// Shared encodings and default sizing for the block data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } dmem_state_t;

  localparam int DMEM_ADDR_WIDTH = 6;
  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_LATENCY    = 5;
  localparam int DMEM_CNT_W      = 4;

endpackage

// File: rtl/dmem_latency_counter.sv
// Access-latency down-counter: loads LOAD_VAL, counts down to zero and holds there.
module dmem_latency_counter
  import dmem_pkg::*;
#(
  parameter logic [DMEM_CNT_W-1:0] LOAD_VAL = DMEM_CNT_W'(DMEM_LATENCY - 1)
) (
  input  logic CLK,
  input  logic RESET,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [DMEM_CNT_W-1:0] count;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/block_data_memory.sv
// Word-organised backing store answering one cache block read/write per request.
// Build option DMEM_CLEAR_ON_RESET_EN: reset also zeroes every word of the array.
module block_data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int LATENCY    = DMEM_LATENCY
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] WRITEDATA,
  output logic [DATA_WIDTH-1:0] READDATA,
  output logic                  BUSYWAIT
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  dmem_state_t           state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  op_write_q;
  logic                  req;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_zero;
  logic                  mem_we;

  assign req      = READ | WRITE;
  assign cnt_load = (state == ST_IDLE) && req;
  assign cnt_dec  = (state == ST_BUSY);
  assign mem_we   = (state == ST_BUSY) && cnt_zero && op_write_q;

  dmem_latency_counter #(
    .LOAD_VAL(DMEM_CNT_W'(LATENCY - 1))
  ) u_latency_counter (
    .CLK  (CLK),
    .RESET(RESET),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  // Stall is raised combinationally in IDLE so the cache never sees a false done.
  always_comb begin
    BUSYWAIT = 1'b0;
    case (state)
      ST_IDLE: BUSYWAIT = req;
      ST_BUSY: BUSYWAIT = 1'b1;
      default: BUSYWAIT = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      READDATA   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr_q     <= ADDRESS;
            wdata_q    <= WRITEDATA;
            op_write_q <= WRITE;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_zero) begin
            if (!op_write_q) begin
              READDATA <= mem[addr_q];
            end
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_CLEAR_ON_RESET_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end
`else
  // Reset forces IDLE asynchronously, which drops mem_we and aborts any pending write.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// Randomised self-checking bench for block_data_memory against an array reference model.
module tb_block_data_memory;

  localparam int LAT = 5;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [5:0]  ADDRESS;
  logic [31:0] WRITEDATA;
  logic [31:0] READDATA;
  logic        BUSYWAIT;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [64];
  logic [31:0] rdata_exp;

  block_data_memory #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(32),
    .LATENCY   (LAT)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .READ     (READ),
    .WRITE    (WRITE),
    .ADDRESS  (ADDRESS),
    .WRITEDATA(WRITEDATA),
    .READDATA (READDATA),
    .BUSYWAIT (BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete access, entered and left on a negedge. The request cycle plus
  // LAT busy cycles must show BUSYWAIT high, then exactly one low DONE cycle.
  task automatic xact(input bit rd, input bit wr, input logic [5:0] a,
                      input logic [31:0] d, input bit scramble);
    int n;
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    #1 chk("busy_on_request", 32'(BUSYWAIT), 32'd1);
    n = 1;
    @(posedge CLK);
    if (scramble) begin
      #1;
      ADDRESS   = 6'($urandom);
      WRITEDATA = $urandom;
      READ      = 1'($urandom);
      WRITE     = 1'($urandom);
    end
    @(negedge CLK);
    while (BUSYWAIT === 1'b1 && n < 40) begin
      n++;
      @(negedge CLK);
    end
    chk("busy_length", 32'(n), 32'(1 + LAT));
    if (wr) mem_m[a] = d;
    else    rdata_exp = mem_m[a];
    chk("readdata_done", READDATA, rdata_exp);
    @(posedge CLK);
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    int k;
    bit rd, wr;
    READ = 0; WRITE = 0; ADDRESS = '0; WRITEDATA = '0;
    RESET = 1'b0;
    rdata_exp = '0;
    for (int i = 0; i < 64; i++) mem_m[i] = 'x;
`ifdef DMEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
`endif
    repeat (3) @(negedge CLK);
    chk("reset_busywait", 32'(BUSYWAIT), 32'd0);
    chk("reset_readdata", READDATA, 32'd0);
    chk("reset_state", 32'(dut.state), 32'd0);
    RESET = 1'b1;
    @(negedge CLK);

`ifdef DMEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 64; i += 9) xact(1, 0, 6'(i), '0, 0);
`endif

    // Populate every word so later random reads compare against known data.
    for (int i = 0; i < 64; i++) xact(0, 1, 6'(i), $urandom, 0);

    xact(0, 1, 6'h2A, 32'hDEADBEEF, 0);
    xact(1, 0, 6'h2A, '0, 0);
    chk("write_read_2a", READDATA, 32'hDEADBEEF);

    // Write-back immediately followed by fill, no idle gap.
    xact(0, 1, 6'h05, 32'h11223344, 0);
    xact(1, 0, 6'h25, '0, 0);
    xact(1, 0, 6'h05, '0, 0);
    chk("b2b_readback", READDATA, 32'h11223344);

    // Address changed while busy must not affect the latched read.
    xact(0, 1, 6'h01, 32'h0BADF00D, 0);
    xact(0, 1, 6'h02, 32'h600DCAFE, 0);
    READ = 1; ADDRESS = 6'h01;
    #1 chk("midchange_busy", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK); #1 ADDRESS = 6'h02;
    k = 1;
    @(negedge CLK);
    while (BUSYWAIT === 1'b1 && k < 40) begin k++; @(negedge CLK); end
    chk("midchange_len", 32'(k), 32'(1 + LAT));
    chk("midchange_data", READDATA, 32'h0BADF00D);
    rdata_exp = 32'h0BADF00D;
    @(posedge CLK); @(negedge CLK); READ = 0;

    // READ and WRITE together: treated as a write, READDATA untouched.
    xact(1, 1, 6'h10, 32'hA5A5A5A5, 0);
    chk("both_readdata_kept", READDATA, 32'h0BADF00D);
    xact(1, 0, 6'h10, '0, 0);
    chk("both_word_written", READDATA, 32'hA5A5A5A5);

    // Reset in the middle of a write to 0x2A aborts it.
    READ = 0; WRITE = 1; ADDRESS = 6'h2A; WRITEDATA = 32'h12345678;
    @(posedge CLK); @(posedge CLK);
    #2 RESET = 1'b0; WRITE = 1'b0;
    #1;
    chk("midreset_state", 32'(dut.state), 32'd0);
    chk("midreset_busywait", 32'(BUSYWAIT), 32'd0);
    chk("midreset_readdata", READDATA, 32'd0);
    rdata_exp = '0;
`ifdef DMEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
`endif
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    xact(1, 0, 6'h2A, '0, 0);
`ifdef DMEM_CLEAR_ON_RESET_EN
    chk("midreset_word", READDATA, 32'd0);
`else
    chk("midreset_word", READDATA, 32'hDEADBEEF);
`endif

    // Random traffic with optional input scrambling during BUSY and idle gaps.
    for (int t = 0; t < 80; t++) begin
      k  = int'($urandom_range(0, 2));
      rd = (k != 1);
      wr = (k != 0);
      xact(rd, wr, 6'($urandom), $urandom, 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge CLK);
          chk("idle_busywait", 32'(BUSYWAIT), 32'd0);
          chk("idle_readdata", READDATA, rdata_exp);
        end
      end
    end

    for (int i = 0; i < 64; i += 7) xact(1, 0, 6'(i), '0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
